// File: rtl/guess_solver_pkg.sv
// Shared definitions for the auto-play guess solver.
// Contents: FSM state enum, the "correct" feedback code, the default guess
// width and width helpers for the feedback code and the try counter.
package guessing_pkg;

   localparam int unsigned DEF_WIDTH  = 4;
   localparam int unsigned FB_CORRECT = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_GUESS,
      S_WAIT,
      S_DONE,
      S_ERROR
   } state_t;

   // Feedback code must encode 0 (correct) and 1..w (highest mismatching bit).
   function automatic int unsigned fb_width(input int unsigned w);
      return $clog2(w + 1);
   endfunction

   // Try counter must reach w+1 without wrapping.
   function automatic int unsigned tries_width(input int unsigned w);
      return $clog2(w + 2);
   endfunction

endpackage

// File: rtl/guess_solver_if.sv
// Solver <-> game bus: start/seed control, comparator feedback, guess output
// and solve status.
//   master: the solver (drives in_number, isGuess, busy, done, found, error, tries)
//   slave : the game side (drives start, seed, state)
interface guess_solver_if
   import guessing_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) ();

   localparam int unsigned CW = fb_width(WIDTH);
   localparam int unsigned TW = tries_width(WIDTH);

   logic             start;
   logic [WIDTH-1:0] seed;
   logic [CW-1:0]    state;
   logic [WIDTH-1:0] in_number;
   logic             isGuess;
   logic             busy;
   logic             done;
   logic             found;
   logic             error;
   logic [TW-1:0]    tries;

   modport master (
      input  start, seed, state,
      output in_number, isGuess, busy, done, found, error, tries
   );

   modport slave (
      output start, seed, state,
      input  in_number, isGuess, busy, done, found, error, tries
   );

endinterface

// File: rtl/guess_solver.sv
// Guess solver: issues guesses to the comparator and, after each miss, flips
// the bit named by the feedback code until the feedback reports a match.
// Ports:
//   clk      - rising-edge clock
//   reset_n  - synchronous active-low reset
//   bus      - guess_solver_if.master (start/seed in, state feedback in,
//              in_number/isGuess/busy/done/found/error/tries out)
module guess_solver
   import guessing_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int unsigned FB_LATENCY = 1
) (
   input  logic           clk,
   input  logic           reset_n,
   guess_solver_if.master bus
);

   localparam int unsigned CW    = fb_width(WIDTH);
   localparam int unsigned TW    = tries_width(WIDTH);
   localparam int unsigned CNT_W = (FB_LATENCY > 1) ? $clog2(FB_LATENCY + 1) : 1;

   state_t           r_state;
   logic [WIDTH-1:0] r_guess;
   logic [CW-1:0]    r_last_code;
   logic [TW-1:0]    r_tries;
   logic [CNT_W-1:0] r_cnt;
   logic             r_is_guess;
   logic             r_busy;
   logic             r_done;
   logic             r_found;
   logic             r_error;

   logic [CW-1:0]    w_code;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_wait_hit;
   logic             w_sample;
   logic             w_correct;
   logic             w_bad;
   logic [WIDTH-1:0] w_flip;

   // Feedback decode; only meaningful when w_sample is high.
   assign w_code     = bus.state;
   assign w_cnt_next = r_cnt + CNT_W'(1);
   assign w_wait_hit = (w_cnt_next == CNT_W'(FB_LATENCY));
   assign w_sample   = ((r_state == S_GUESS) && (FB_LATENCY == 0)) ||
                       ((r_state == S_WAIT) && w_wait_hit);
   assign w_correct  = (w_code == CW'(FB_CORRECT));
   // Codes must strictly decrease within a solve; anything else is a broken comparator.
   assign w_bad      = (32'(w_code) > WIDTH) || (w_code >= r_last_code);
   assign w_flip     = WIDTH'(1) << (w_code - CW'(1));

   // Solver FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_guess     <= '0;
         r_last_code <= CW'(WIDTH + 1);
         r_tries     <= '0;
         r_cnt       <= '0;
         r_is_guess  <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_found     <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_is_guess <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (bus.start) begin
                  r_state     <= S_GUESS;
                  r_guess     <= bus.seed;
                  r_tries     <= '0;
                  r_last_code <= CW'(WIDTH + 1);
                  r_is_guess  <= 1'b1;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_found     <= 1'b0;
                  r_error     <= 1'b0;
               end
            end
            S_GUESS, S_WAIT: begin
               if (r_state == S_GUESS) begin
                  r_tries <= r_tries + TW'(1);
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_next;
               end
               if (w_sample) begin
                  if (w_correct) begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_found <= 1'b1;
                  end else if (w_bad) begin
                     r_state <= S_ERROR;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_error <= 1'b1;
                  end else begin
                     r_state     <= S_GUESS;
                     r_guess     <= r_guess ^ w_flip;
                     r_last_code <= w_code;
                     r_is_guess  <= 1'b1;
                  end
               end else begin
                  r_state <= S_WAIT;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_number = r_guess;
   assign bus.isGuess   = r_is_guess;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.found     = r_found;
   assign bus.error     = r_error;
   assign bus.tries     = r_tries;

endmodule

// File: tb/tb_guess_solver.sv
// Bench for guess_solver: two instances (feedback latency 1 and 0) driven by a
// comparator model, with a forcing mode that supplies feedback codes directly.
// A solve-level model predicts every output on every cycle.
module tb_guess_solver;
   import guessing_pkg::*;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   guess_solver_if #(.WIDTH(4)) if1 ();
   guess_solver_if #(.WIDTH(4)) if0 ();

   guess_solver #(.WIDTH(4), .FB_LATENCY(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
   guess_solver #(.WIDTH(4), .FB_LATENCY(0)) dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));

   int         checks    = 0;
   int         failures  = 0;
   int         cyc       = 0;
   bit         chk_en    = 1'b0;
   logic [3:0] secret    = 4'd0;
   bit         force_mode = 1'b0;
   logic [2:0] fcodes [4];
   int         pulse_cnt = 0;
   bit         pulse_clr = 1'b0;

   // Solve-level model state, one slot per instance (index 1: latency 1, index 0: latency 0).
   logic [3:0] plan_g [2][8];
   int         plan_n      [2];
   bit         plan_found  [2];
   int         plan_start  [2];
   bit         plan_active [2];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (pulse_clr)        pulse_cnt <= 0;
      else if (if1.isGuess) pulse_cnt <= pulse_cnt + 1;
   end

   // Comparator: code = index+1 of the highest mismatching bit, 0 on match.
   function automatic logic [2:0] hi_mismatch(input logic [3:0] a, input logic [3:0] b);
      for (int k = 3; k >= 0; k--)
         if (a[k] != b[k]) return 3'(k + 1);
      return 3'd0;
   endfunction

   always_comb begin
      if1.state = hi_mismatch(if1.in_number, secret);
      if (force_mode)
         if1.state = (pulse_cnt > 0 && pulse_cnt <= 4) ? fcodes[pulse_cnt-1] : 3'd0;
      if0.state = hi_mismatch(if0.in_number, secret);
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at cyc %0d: got %0d want %0d", nm, cyc, act, exp);
      end
   endtask

   // Guess list and outcome of one solve, from the game rules.
   task automatic build_plan(input int d, input logic [3:0] sd, input bit use_cmp,
                             input logic [3:0] sec);
      logic [3:0] g;
      int         last;
      int         code;
      bit         fin;
      g = sd; last = 5; fin = 1'b0; plan_n[d] = 0;
      while (!fin && plan_n[d] < 8) begin
         plan_g[d][plan_n[d]] = g;
         plan_n[d]++;
         code = use_cmp ? int'(hi_mismatch(g, sec)) : int'(fcodes[plan_n[d]-1]);
         if (code == 0) begin
            plan_found[d] = 1'b1; fin = 1'b1;
         end else if (code > 4 || code >= last) begin
            plan_found[d] = 1'b0; fin = 1'b1;
         end else begin
            g = g ^ (4'b0001 << (code - 1));
            last = code;
         end
      end
   endtask

   // Expected outputs at the current cycle derived from the solve plan.
   task automatic check_outputs(input int d, input logic [3:0] num, input logic g,
                                input logic b, input logic dn, input logic f,
                                input logic e, input logic [2:0] t);
      int L, r, i, k;
      logic [3:0] x_num;
      bit x_g, x_b, x_d, x_f, x_e;
      int x_t;
      L = (d == 1) ? 1 : 0;
      x_num = 4'd0; x_g = 0; x_b = 0; x_d = 0; x_f = 0; x_e = 0; x_t = 0;
      if (plan_active[d]) begin
         r = cyc - plan_start[d];
         if (r < plan_n[d] * (L + 1)) begin
            i = r / (L + 1);
            k = r % (L + 1);
            x_num = plan_g[d][i];
            x_g   = (k == 0);
            x_b   = 1'b1;
            x_t   = (k == 0) ? i : i + 1;
         end else begin
            x_num = plan_g[d][plan_n[d]-1];
            x_d   = 1'b1;
            x_f   = plan_found[d];
            x_e   = !plan_found[d];
            x_t   = plan_n[d];
         end
      end
      chk($sformatf("dut%0d.in_number", d), int'(num), int'(x_num));
      chk($sformatf("dut%0d.isGuess", d), int'(g), int'(x_g));
      chk($sformatf("dut%0d.busy", d), int'(b), int'(x_b));
      chk($sformatf("dut%0d.done", d), int'(dn), int'(x_d));
      chk($sformatf("dut%0d.found", d), int'(f), int'(x_f));
      chk($sformatf("dut%0d.error", d), int'(e), int'(x_e));
      chk($sformatf("dut%0d.tries", d), int'(t), x_t);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check_outputs(1, if1.in_number, if1.isGuess, if1.busy, if1.done, if1.found,
                       if1.error, if1.tries);
         check_outputs(0, if0.in_number, if0.isGuess, if0.busy, if0.done, if0.found,
                       if0.error, if0.tries);
      end
   end

   // Accept a start at the next edge N and register the predicted solve.
   task automatic go(input int d, input logic [3:0] sd, input bit use_cmp,
                     input logic [3:0] sec);
      secret = sec; force_mode = !use_cmp; pulse_clr = 1'b1;
      if (d == 1) begin if1.seed = sd; if1.start = 1'b1; end
      else        begin if0.seed = sd; if0.start = 1'b1; end
      @(posedge clk); #1;
      if1.start = 1'b0; if0.start = 1'b0; pulse_clr = 1'b0;
      build_plan(d, sd, use_cmp, sec);
      plan_start[d]  = cyc;
      plan_active[d] = 1'b1;
   endtask

   // Land on the negedge of cycle N+c, where N is the start edge of instance d.
   task automatic wait_spec(input int d, input int c);
      int target;
      target = plan_start[d] + c - 1;
      while (cyc < target) begin @(posedge clk); #1; end
      @(negedge clk);
   endtask

   initial begin
      if1.start = 1'b0; if1.seed = 4'd0; if0.start = 1'b0; if0.seed = 4'd0;
      fcodes = '{default: 3'd0};
      plan_active = '{default: 1'b0};
      plan_n = '{default: 1};
      plan_start = '{default: 0};
      plan_found = '{default: 1'b0};
      repeat (3) @(posedge clk);
      #1; reset_n = 1'b1; chk_en = 1'b1;

      // Comparator codes for the 1010 walk.
      chk("cmp 0000v1010", int'(hi_mismatch(4'b0000, 4'b1010)), 4);
      chk("cmp 1000v1010", int'(hi_mismatch(4'b1000, 4'b1010)), 2);
      chk("cmp 1010v1010", int'(hi_mismatch(4'b1010, 4'b1010)), 0);

      // Secret 1010 from seed 0000.
      go(1, 4'b0000, 1'b1, 4'b1010);
      chk("plan1 n", plan_n[1], 3);
      chk("plan1 g1", int'(plan_g[1][1]), 4'b1000);
      chk("plan1 g2", int'(plan_g[1][2]), 4'b1010);
      wait_spec(1, 3);
      chk("t1 guess2", int'(if1.in_number), 4'b1000);
      wait_spec(1, 6);
      chk("t1 done early", int'(if1.done), 0);
      wait_spec(1, 7);
      chk("t1 done", int'(if1.done), 1);
      chk("t1 found", int'(if1.found), 1);
      chk("t1 tries", int'(if1.tries), 3);

      // Seed equals secret, started from DONE.
      go(1, 4'b0110, 1'b1, 4'b0110);
      wait_spec(1, 1);
      chk("t2 done drop", int'(if1.done), 0);
      chk("t2 seed", int'(if1.in_number), 4'b0110);
      wait_spec(1, 3);
      chk("t2 found", int'(if1.found), 1);
      chk("t2 tries", int'(if1.tries), 1);

      // Secret 1111 from 0000 at both latencies.
      go(1, 4'b0000, 1'b1, 4'b1111);
      chk("plan3 n", plan_n[1], 5);
      wait_spec(1, 10);
      chk("t3 done early", int'(if1.done), 0);
      wait_spec(1, 11);
      chk("t3 done", int'(if1.done), 1);
      chk("t3 tries", int'(if1.tries), 5);
      go(0, 4'b0000, 1'b1, 4'b1111);
      wait_spec(0, 5);
      chk("t3l0 done early", int'(if0.done), 0);
      wait_spec(0, 6);
      chk("t3l0 done", int'(if0.done), 1);
      chk("t3l0 tries", int'(if0.tries), 5);

      // Forced illegal code on the first sample.
      fcodes[0] = 3'b101;
      go(1, 4'b0011, 1'b0, 4'b0000);
      wait_spec(1, 3);
      chk("f1 error", int'(if1.error), 1);
      chk("f1 found", int'(if1.found), 0);
      chk("f1 tries", int'(if1.tries), 1);

      // Forced non-monotonic codes 2 then 3.
      fcodes[0] = 3'b010; fcodes[1] = 3'b011;
      go(1, 4'b0000, 1'b0, 4'b0000);
      wait_spec(1, 4);
      chk("f2 error early", int'(if1.error), 0);
      wait_spec(1, 5);
      chk("f2 error", int'(if1.error), 1);
      chk("f2 tries", int'(if1.tries), 2);
      chk("f2 guess", int'(if1.in_number), 4'b0010);

      // Reset during WAIT of the second guess.
      go(1, 4'b0000, 1'b1, 4'b1010);
      wait_spec(1, 4);
      reset_n = 1'b0;
      @(posedge clk); #1;
      plan_active[0] = 1'b0; plan_active[1] = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst busy", int'(if1.busy), 0);
      chk("rst num", int'(if1.in_number), 0);
      chk("rst tries", int'(if1.tries), 0);
      chk("rst done l0", int'(if0.done), 0);

      // Fresh solve with a start pulse while busy that must be ignored.
      go(1, 4'b0011, 1'b1, 4'b1010);
      wait_spec(1, 2);
      if1.seed = 4'b1111; if1.start = 1'b1;
      @(posedge clk); #1;
      if1.start = 1'b0;
      wait_spec(1, 7);
      chk("t4 found", int'(if1.found), 1);
      chk("t4 tries", int'(if1.tries), 3);
      chk("t4 num", int'(if1.in_number), 4'b1010);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/guess_solver.md
# guess_solver

Sequential counterpart to the guessing-game comparator. It issues 4-bit guesses (`in_number`, strobed by `isGuess`) and consumes the comparator's 3-bit `state` feedback, which reports the highest mismatching bit. After each miss it flips the indicated bit and guesses again until the feedback reports a match. It sits between the game's input stage and the comparator, replacing manual switch entry in auto-play mode.

## Interface
- `WIDTH`, 4: guess/secret width; feedback code width is `clog2(WIDTH+1)` (3 at default).
- `FB_LATENCY`, 1: cycles between the `isGuess` pulse cycle and the feedback sample cycle (0 = sample in the pulse cycle).
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a solve; accepted only in IDLE/DONE/ERROR.
- `seed`  in  WIDTH  first guess; latched on accepted `start`.
- `state`  in  3  comparator feedback: 0 = correct; k (1..WIDTH) = bit k-1 is the highest mismatch.
- `in_number`  out  WIDTH  current guess, registered, stable between pulses.
- `isGuess`  out  1  one-cycle strobe per guess.
- `busy`  out  1  high in GUESS/WAIT.
- `done`  out  1  level, high in DONE or ERROR until next accepted `start`.
- `found`  out  1  high in DONE only.
- `error`  out  1  high in ERROR only.
- `tries`  out  `clog2(WIDTH+2)`  guesses issued in the current/last solve.

## Operation
- FSM: IDLE, GUESS, WAIT, DONE, ERROR.
- IDLE/DONE/ERROR + `start`: latch `in_number <= seed`, `tries <= 0`, `last_code <= WIDTH+1`; go to GUESS.
- GUESS: `isGuess = 1`, `tries <= tries+1`, clear wait counter. If `FB_LATENCY == 0`, sample in this cycle; otherwise go to WAIT.
- WAIT: count up; sample when count reaches `FB_LATENCY`.
- Sample rules, evaluated in priority order:
  - code == 0: go to DONE.
  - code > WIDTH, or code >= `last_code`: go to ERROR (non-monotonic or illegal feedback).
  - otherwise: `in_number[code-1] <= ~in_number[code-1]`, `last_code <= code`, go to GUESS.
- Monotonic feedback bounds a solve to at most WIDTH+1 guesses; `tries` never wraps.
- `start` during GUESS/WAIT is ignored.
- In DONE/ERROR, `in_number` and `tries` hold their final values.
- Reset values: state IDLE; `in_number` 0; `isGuess`, `busy`, `done`, `found`, `error` all 0; `tries` 0; `last_code` WIDTH+1.
- `reset_n` low at any edge, mid-solve included, forces reset values at that edge. No guess is pending afterwards.

## Timing
- Accepted `start` at edge N: first `isGuess` in cycle N+1.
- Each guess occupies FB_LATENCY+1 cycles. The next `isGuess` follows the sample cycle immediately.
- For a solve of n guesses: `done` rises at cycle N+1+n·(FB_LATENCY+1).
- `in_number` changes only on the edge entering GUESS, so it is stable in the pulse cycle and through WAIT.
- `state` is sampled only on the sample cycle; all other values are don't-care.

## Structure
- Package `guessing_pkg` holds:
  - FSM state enum;
  - `FB_CORRECT = 0`;
  - the feedback code width function and default `WIDTH`.
- Single module, no sub-module; the wait counter and the bit-flip logic stay inline.
- Bench instantiates `guess_solver` back-to-back with the comparator, plus a forcing mode that drives `state` directly.

## Test plan
- Secret 1010, seed 0000, FB_LATENCY 1, start at cycle 0:
  - guesses 0000, 1000, 1010;
  - feedback codes 100, 010, 000;
  - `done`/`found` at cycle 7, `tries` = 3.
- Seed equals secret 0110: single guess; `done`/`found` at cycle 3, `tries` = 1.
- Secret 1111, seed 0000: guesses 0000, 1000, 1100, 1110, 1111; `tries` = 5; `done` at cycle 11. Repeat with FB_LATENCY 0: `done` at cycle 6.
- Forced feedback:
  - code 101 on the first sample: `error` = 1, `found` = 0, `tries` = 1;
  - codes 010 then 011: ERROR after the second guess.
- `reset_n` low during WAIT of the second guess: next edge IDLE with all outputs 0. A fresh `start` then solves normally.
- `start` pulsed while `busy`: no restart, sequence unchanged. `start` from DONE: new seed latched, `done` drops the next cycle.
